// File: rtl/chan_packet_snap_ctrl.sv
// chan_packet_snap_ctrl: sequences snapshot captures of the channelizer packet
// stream into the snap BRAM. Software arms it through the startSnap control
// word and polls completion through the status word.
//
// Handshake: din is accepted only on cycles where din_valid=1 and the
// sequencer is collecting (CAPTURE, or ARMED while ext_trig=1). There is no
// back-pressure. Each accepted word appears on the BRAM write port exactly one
// cycle later as a single bram_we pulse.
module chan_packet_snap_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       ctrl_reg,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              ext_trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  output logic              busy,
  output logic              done,
  output logic [31:0]       status_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_arm_q;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_din;

  logic                w_arm_edge;
  logic                w_abort;
  logic                w_start;
  logic                w_wr;
  logic                w_last;
  logic [1:0]          w_state_bits;
  logic [15:0]         w_words;
  logic                w_unused;

  // Only arm, use_trig, abort and the length field carry meaning.
  assign w_unused = ^ctrl_reg;

  // A held arm level must not restart a capture; only its rising edge does.
  assign w_arm_edge = ctrl_reg[0] & ~r_arm_q;
  assign w_abort    = ctrl_reg[2];
  assign w_start    = w_arm_edge & ~w_abort &
                      ((r_state == S_IDLE) | (r_state == S_DONE));

  // The trigger cycle itself already collects data when din_valid is high.
  assign w_wr   = ~w_abort & din_valid &
                  ((r_state == S_CAPTURE) | ((r_state == S_ARMED) & ext_trig));
  // r_cnt counts words already accepted, so this word is number r_cnt+1.
  assign w_last = w_wr & (r_cnt == {1'b0, r_len});

  // Next-state selection; abort dominates everything including a new arm edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_arm_edge) w_state_nxt = ctrl_reg[1] ? S_ARMED : S_CAPTURE;
        end
        S_ARMED: begin
          if (ext_trig) w_state_nxt = w_last ? S_DONE : S_CAPTURE;
        end
        S_CAPTURE: begin
          if (w_last) w_state_nxt = S_DONE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge user_clk) begin
    if (user_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Arm-edge history, latched length, word counter and the BRAM write stage.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_arm_q <= 1'b0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_din   <= '0;
    end else begin
      r_arm_q <= ctrl_reg[0];
      r_we    <= w_wr;
      if (w_wr) begin
        r_addr <= r_cnt[ADDR_W-1:0];
        r_din  <= din;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_abort) begin
        r_cnt <= '0;
      end else if (w_start) begin
        r_cnt <= '0;
        r_len <= ctrl_reg[16 +: ADDR_W];
      end
    end
  end

  assign w_state_bits = r_state;
  assign w_words      = {{(15 - ADDR_W){1'b0}}, r_cnt};

  assign bram_addr  = r_addr;
  assign bram_we    = r_we;
  assign bram_din   = r_din;
  assign busy       = (r_state == S_ARMED) | (r_state == S_CAPTURE);
  assign done       = (r_state == S_DONE);
  assign status_out = {w_state_bits, done, 13'b0, w_words};

endmodule

// File: tb/tb_chan_packet_snap_ctrl.sv
// Bench for chan_packet_snap_ctrl: random captures checked against a
// capture-level reference that lists which din words must land where.
module tb_chan_packet_snap_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [31:0]       ctrl_reg;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              ext_trig;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              done;
  logic [31:0]       status_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] mon_e;

  chan_packet_snap_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .ctrl_reg   (ctrl_reg),
    .din        (din),
    .din_valid  (din_valid),
    .ext_trig   (ext_trig),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_din   (bram_din),
    .busy       (busy),
    .done       (done),
    .status_out (status_out)
  );

  // Clock
  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every BRAM write must match the next expected (addr, data).
  always @(negedge user_clk) begin
    if (bram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_write", 64'(bram_addr), 64'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bram_addr), 64'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data", 64'(bram_din), 64'(mon_e[DATA_W-1:0]));
      end
    end
  end

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  // Status word as software should see it for a given phase and word count.
  function automatic logic [31:0] exp_status(input int st, input int ww);
    logic [1:0]  s;
    logic [15:0] w;
    s = 2'(st);
    w = 16'(ww);
    return {s, (st == 3), 13'b0, w};
  endfunction

  task automatic expect_phase(input string tag, input int st, input int ww);
    check({tag, "_status"}, 64'(status_out), 64'(exp_status(st, ww)));
    check({tag, "_busy"}, 64'(busy), 64'((st == 1) || (st == 2)));
    check({tag, "_done"}, 64'(done), 64'(st == 3));
  endtask

  // One complete capture: arm edge, collection with random gaps/noise, then
  // a few quiet cycles that must produce no further writes.
  task automatic do_capture(input int len, input bit trig, input int trig_at, input int vprob);
    logic [31:0] c;
    logic [31:0] r;
    int          written;
    bit          triggered;
    bit          qual;
    int          cyc;
    ctrl_reg = '0; din_valid = 1'b0; ext_trig = 1'b0;
    step();
    c = '0;
    c[16 +: ADDR_W] = ADDR_W'(len);
    c[1] = trig;
    c[0] = 1'b1;
    ctrl_reg  = c;
    din       = $urandom;
    din_valid = 1'($urandom_range(0, 1));
    ext_trig  = 1'($urandom_range(0, 1));
    step();
    written   = 0;
    triggered = !trig;
    expect_phase("arm", trig ? 1 : 2, 0);
    cyc = 0;
    while (written < len + 1 && cyc < 4000) begin
      r = $urandom;
      ctrl_reg  = {r[31:16], 13'b0, 1'b0, r[1], 1'b1};
      din       = $urandom;
      din_valid = ($urandom_range(0, 99) < vprob);
      if (!triggered) ext_trig = (cyc == trig_at);
      else            ext_trig = 1'($urandom_range(0, 1));
      if (ext_trig) triggered = 1'b1;
      qual = triggered && din_valid;
      if (qual) begin
        exp_q.push_back({ADDR_W'(written), din});
        written++;
      end
      step();
      check("we_cycle", 64'(bram_we), 64'(qual));
      expect_phase("cap", (written == len + 1) ? 3 : (triggered ? 2 : 1), written);
      cyc++;
    end
    if (written < len + 1) check("timeout", 64'(written), 64'(len + 1));
    ctrl_reg = c; din_valid = 1'b1; ext_trig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_we", 64'(bram_we), 64'd0);
      expect_phase("post", 3, len + 1);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] c;
    user_rst = 1'b1; ctrl_reg = '0; din = '0; din_valid = 1'b0; ext_trig = 1'b0;
    repeat (3) step();
    check("rst_addr", 64'(bram_addr), 64'd0);
    check("rst_we", 64'(bram_we), 64'd0);
    check("rst_din", 64'(bram_din), 64'd0);
    expect_phase("rst", 0, 0);
    user_rst = 1'b0;
    step();
    expect_phase("idle", 0, 0);

    // Immediate, continuous; then triggered at cycle 20; then gappy input.
    do_capture(3, 1'b0, 0, 100);
    do_capture(7, 1'b1, 20, 100);
    do_capture(3, 1'b0, 0, 50);
    // Single-word captures, including the trigger cycle being the last word.
    do_capture(0, 1'b1, 3, 100);
    do_capture(0, 1'b0, 0, 60);

    // Abort after two of eight words with arm held high.
    ctrl_reg = '0; step();
    c = '0; c[16 +: ADDR_W] = ADDR_W'(7); c[0] = 1'b1;
    ctrl_reg = c; din_valid = 1'b0; step();
    expect_phase("ab_arm", 2, 0);
    for (int i = 0; i < 2; i++) begin
      din = $urandom; din_valid = 1'b1;
      exp_q.push_back({ADDR_W'(i), din});
      step();
    end
    ctrl_reg = c | 32'h4; din = $urandom; step();
    check("abort_we", 64'(bram_we), 64'd0);
    expect_phase("abort", 0, 0);
    ctrl_reg = c;
    for (int i = 0; i < 4; i++) begin
      din = $urandom; step();
      check("held_we", 64'(bram_we), 64'd0);
      expect_phase("held", 0, 0);
    end
    do_capture(5, 1'b0, 0, 80);
    ctrl_reg = 32'h4; step();
    expect_phase("abort_done", 0, 0);

    // Random captures.
    for (int n = 0; n < 12; n++)
      do_capture($urandom_range(0, 40), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15), $urandom_range(25, 100));

    // Full depth: 1024 words, no wrap.
    do_capture((1 << ADDR_W) - 1, 1'b0, 0, 100);

    // Reset in the middle of a capture after five words.
    ctrl_reg = '0; step();
    c = '0; c[16 +: ADDR_W] = ADDR_W'(9); c[0] = 1'b1;
    ctrl_reg = c; din_valid = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      din = $urandom; din_valid = 1'b1;
      exp_q.push_back({ADDR_W'(i), din});
      step();
    end
    user_rst = 1'b1; ctrl_reg = '0; din = $urandom; step();
    check("mrst_addr", 64'(bram_addr), 64'd0);
    check("mrst_we", 64'(bram_we), 64'd0);
    check("mrst_din", 64'(bram_din), 64'd0);
    expect_phase("mrst", 0, 0);
    user_rst = 1'b0; din_valid = 1'b0; step();
    do_capture(6, 1'b0, 0, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
